// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register and write-back datapath.
// It captures the MEM-stage instruction, extracts and extends load data,
// selects the write-back source and drives the register-file write port.
// It also exports a forwarding bypass and counts retired instructions.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_*              instruction fields presented by the MEM stage
//   stall             hold the WB register and the retire counter
//   flush             kill the incoming instruction (stall has priority)
//   rf_we/rf_wr/rf_wd register-file write port, decoded from the WB register
//   fwd_valid/fwd_rd/fwd_data  bypass copy of the write port
//   load_err          MEM-sourced load with an unsupported funct3
//   instret           retired-instruction counter, wraps silently
module wb_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [4:0]       in_rd,
  input  logic             in_rf_we,
  input  logic [1:0]       in_rf_wsel,
  input  logic [XLEN-1:0]  in_aluc,
  input  logic [XLEN-1:0]  in_ext,
  input  logic [XLEN-1:0]  in_pc4,
  input  logic [XLEN-1:0]  in_mem_rdata,
  input  logic [2:0]       in_funct3,
  input  logic             stall,
  input  logic             flush,
  output logic             rf_we,
  output logic [4:0]       rf_wr,
  output logic [XLEN-1:0]  rf_wd,
  output logic             fwd_valid,
  output logic [4:0]       fwd_rd,
  output logic [XLEN-1:0]  fwd_data,
  output logic             load_err,
  output logic [CNT_W-1:0] instret
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;

  localparam logic [1:0] WSEL_ALU = 2'b00;
  localparam logic [1:0] WSEL_EXT = 2'b01;
  localparam logic [1:0] WSEL_PC4 = 2'b10;
  localparam logic [1:0] WSEL_MEM = 2'b11;

  typedef struct packed {
    logic [4:0]      rd;
    logic            we;
    logic [1:0]      wsel;
    logic [XLEN-1:0] aluc;
    logic [XLEN-1:0] ext;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] mem_rdata;
    logic [2:0]      funct3;
  } wb_reg_t;

  logic             valid_q;
  wb_reg_t          r_q;
  logic [CNT_W-1:0] instret_q;

  logic [BYTE_W-1:0] ld_byte;
  logic [HALF_W-1:0] ld_half;
  logic [XLEN-1:0]   ld_data;
  logic              ld_illegal;
  logic [XLEN-1:0]   wd_mux;
  logic              load_err_c;

  // MEM/WB register and retire counter; stall freezes both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      r_q       <= '0;
      instret_q <= '0;
    end else if (!stall) begin
      valid_q         <= in_valid & ~flush;
      r_q.rd          <= in_rd;
      r_q.we          <= in_rf_we;
      r_q.wsel        <= in_rf_wsel;
      r_q.aluc        <= in_aluc;
      r_q.ext         <= in_ext;
      r_q.pc4         <= in_pc4;
      r_q.mem_rdata   <= in_mem_rdata;
      r_q.funct3      <= in_funct3;
      // Counts the instruction leaving WB on this edge.
      if (valid_q) instret_q <= instret_q + CNT_W'(1);
    end
  end

  // Little-endian lane select and load extension.
  always_comb begin
    ld_byte    = '0;
    ld_half    = '0;
    ld_data    = '0;
    ld_illegal = 1'b0;
    case (r_q.aluc[1:0])
      2'd0:    ld_byte = r_q.mem_rdata[7:0];
      2'd1:    ld_byte = r_q.mem_rdata[15:8];
      2'd2:    ld_byte = r_q.mem_rdata[23:16];
      default: ld_byte = r_q.mem_rdata[31:24];
    endcase
    ld_half = r_q.aluc[1] ? r_q.mem_rdata[31:16] : r_q.mem_rdata[15:0];
    case (r_q.funct3)
      3'b000:  ld_data = {{(XLEN-BYTE_W){ld_byte[BYTE_W-1]}}, ld_byte};
      3'b001:  ld_data = {{(XLEN-HALF_W){ld_half[HALF_W-1]}}, ld_half};
      3'b010:  ld_data = r_q.mem_rdata;
      3'b100:  ld_data = {{(XLEN-BYTE_W){1'b0}}, ld_byte};
      3'b101:  ld_data = {{(XLEN-HALF_W){1'b0}}, ld_half};
      default: ld_illegal = 1'b1;
    endcase
  end

  // Write-back source select.
  always_comb begin
    wd_mux = '0;
    case (r_q.wsel)
      WSEL_ALU: wd_mux = r_q.aluc;
      WSEL_EXT: wd_mux = r_q.ext;
      WSEL_PC4: wd_mux = r_q.pc4;
      WSEL_MEM: wd_mux = ld_data;
      default:  wd_mux = '0;
    endcase
  end

  assign load_err_c = valid_q & (r_q.wsel == WSEL_MEM) & ld_illegal;

  // Write port decode; x0 and faulting loads never write.
  assign rf_we     = valid_q & r_q.we & (r_q.rd != 5'd0) & ~load_err_c;
  assign rf_wr     = valid_q ? r_q.rd : 5'd0;
  assign rf_wd     = valid_q ? wd_mux : '0;
  assign fwd_valid = rf_we;
  assign fwd_rd    = rf_wr;
  assign fwd_data  = rf_wd;
  assign load_err  = load_err_c;
  assign instret   = instret_q;

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Pipelined write-back stage sitting at the far end of the register-file write interface: the producer of the RF write port (wR/we/wD) that the decode stage's register file consumes.
- Holds the MEM/WB pipeline register.
- Extracts and sign/zero-extends load data.
- Selects the write-back source, suppresses x0 writes, exports a forwarding bypass and counts retired instructions.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  MEM stage presents a valid instruction
- in_rd  input  5  destination register (inst[11:7])
- in_rf_we  input  1  instruction writes the RF
- in_rf_wsel  input  2  write-back source: 00 ALU, 01 EXT, 10 PC4, 11 MEM
- in_aluc  input  XLEN  ALU result; its low 2 bits are the load byte offset
- in_ext  input  XLEN  immediate from SEXT
- in_pc4  input  XLEN  pc+4
- in_mem_rdata  input  XLEN  raw aligned memory word
- in_funct3  input  3  load type
- stall  input  1  hold the WB register
- flush  input  1  kill the incoming instruction
- rf_we  output  1  RF write enable
- rf_wr  output  5  RF write address
- rf_wd  output  XLEN  RF write data
- fwd_valid  output  1  bypass is live (same as rf_we)
- fwd_rd  output  5  bypass destination
- fwd_data  output  XLEN  bypass data (same as rf_wd)
- load_err  output  1  registered instruction is a MEM-sourced load with an illegal funct3
- instret  output  CNT_W  retired-instruction count

Behaviour:
- Reset (async, rst_n low): valid_q=0, all captured fields=0, instret=0. Consequently rf_we=0, rf_wr=0, rf_wd=0, fwd_valid=0, fwd_rd=0, fwd_data=0, load_err=0.
- Capture on every rising clk edge unless stall=1:
  - valid_q <= in_valid & ~flush.
  - All data fields load from the in_* ports regardless of valid.
- stall=1: the register holds all contents and instret does not increment.
- stall and flush both high: stall wins; the register holds and flush is ignored that cycle.
- Latency: one cycle from the in_* ports to rf_*. The rf_* outputs are combinational from the register, so the RF commits on the following edge.
- rf_we = valid_q & rf_we_q & (rd_q != 0) & ~load_err. x0 is never written.
- rf_wr = rd_q whenever valid_q=1, else 0.
- Load extraction, only when wsel_q=11. off = aluc_q[1:0].
  - 000 LB: sign-extend byte[off].
  - 001 LH: sign-extend halfword[aluc_q[1]].
  - 010 LW: full word; offset ignored.
  - 100 LBU: zero-extend byte[off].
  - 101 LHU: zero-extend halfword[aluc_q[1]].
  - Any other funct3: data=0 and load_err=valid_q.
  - Byte/halfword lane selection is little-endian.
- Write-data mux on wsel_q: 00 aluc_q, 01 ext_q, 10 pc4_q, 11 extracted load. rf_wd is forced to 0 when valid_q=0.
- Retire counter:
  - On each edge with stall=0 and valid_q=1, instret increments by 1. This counts the instruction leaving WB, including those with rf_we=0 and those with load_err.
  - Wraps from all-ones to 0 silently.
- Reset asserted mid-operation clears state immediately. The first capture happens on the first edge after rst_n rises.

Test Plan:
- Reset: rst_n=0 with arbitrary inputs -> all outputs 0. Release, then drive in_valid=1, rd=5, we=1, wsel=00, aluc=0x1234 -> next cycle rf_we=1, rf_wr=5, rf_wd=0x00001234, instret=0; after one more edge instret=1.
- Loads: mem_rdata=0x80FF7F01.
  - LB off=3 -> 0xFFFFFF80.
  - LBU off=1 -> 0x0000007F.
  - LH aluc=..2 -> 0xFFFF80FF.
  - LHU aluc=..0 -> 0x00007F01.
  - LW -> 0x80FF7F01.
  - funct3=011 -> rf_we=0, load_err=1.
- Sources: wsel=01 ext=0xFFFFF800 -> rf_wd=0xFFFFF800; wsel=10 pc4=0x00000104 -> rf_wd=0x104; rd=0 with we=1 -> rf_we=0 and instret still increments.
- Stall/flush:
  - Instruction A captured, then stall=1 for 3 cycles while inputs change -> outputs stay A and instret is frozen.
  - stall=1 with flush=1 -> hold.
  - flush=1 alone -> next cycle rf_we=0, rf_wd=0.
- Counter wrap: preload by running 2^CNT_W retirements (CNT_W=4 in the bench) -> instret goes 15 -> 0.
- Async reset mid-stream: assert rst_n low between edges while rf_we=1 -> rf_we drops without a clock edge and instret=0.
